// File: rtl/cov_pkg.sv
// Shared definitions for both ends of the covariance engine: controller states and the
// packing of the strict upper triangle into a flat word list.
package cov_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_STREAM    = 2'd3
    } state_t;

    localparam int N_DEFAULT = 4;
    localparam int NUM_UPPER = N_DEFAULT * (N_DEFAULT - 1) / 2;

    function automatic int num_upper(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Row-major position of (r,c), r<c, among the upper-triangle words
    function automatic int upper_idx(input int n, input int r, input int c);
        return r * (2 * n - r - 1) / 2 + (c - r - 1);
    endfunction

    // Two's-complement negation that maps the most negative w-bit value to the most positive
    function automatic longint sat_neg(input longint x, input int w);
        longint lo;
        lo = -(longint'(1) <<< (w - 1));
        return (x == lo) ? (-lo - 1) : -x;
    endfunction

endpackage

// File: rtl/cov_matrix_reader_if.sv
// Row-major Hermitian element stream toward the eigen-decomposition stage.
interface cov_matrix_reader_if #(
    parameter int N         = 4,
    parameter int ACC_WIDTH = 20
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic                        om_valid;
    logic                        im_ready;
    logic signed [ACC_WIDTH-1:0] om_re;
    logic signed [ACC_WIDTH-1:0] om_im;
    logic [RW-1:0]               om_row;
    logic [RW-1:0]               om_col;
    logic                        om_last;

    modport master (output om_valid, om_re, om_im, om_row, om_col, om_last, input im_ready);
    modport slave  (input om_valid, om_re, om_im, om_row, om_col, om_last, output im_ready);
endinterface

// File: rtl/cov_elem_sel.sv
// Combinational pick of element (row,col) from the captured packed result; the lower
// triangle is rebuilt as the saturated conjugate of its upper-triangle mirror.
module cov_elem_sel
    import cov_pkg::*;
#(
    parameter int  N         = 4,
    parameter int  ACC_WIDTH = 20,
    localparam int NU        = num_upper(N),
    localparam int RW        = (N > 1) ? $clog2(N) : 1,
    localparam int KW        = (NU > 1) ? $clog2(NU) : 1
) (
    input  logic [N*ACC_WIDTH-1:0]     i_cap_diag,
    input  logic [NU*ACC_WIDTH-1:0]    i_cap_q,
    input  logic [NU*ACC_WIDTH-1:0]    i_cap_i,
    input  logic [RW-1:0]              i_row,
    input  logic [RW-1:0]              i_col,
    output logic signed [ACC_WIDTH-1:0] o_re,
    output logic signed [ACC_WIDTH-1:0] o_im
);

    logic signed [ACC_WIDTH-1:0] w_diag [N];
    logic signed [ACC_WIDTH-1:0] w_q    [NU];
    logic signed [ACC_WIDTH-1:0] w_i    [NU];
    logic [KW-1:0]               w_k;

    for (genvar g = 0; g < N; g++) begin : g_diag
        assign w_diag[g] = i_cap_diag[g*ACC_WIDTH +: ACC_WIDTH];
    end

    for (genvar g = 0; g < NU; g++) begin : g_upper
        assign w_q[g] = i_cap_q[g*ACC_WIDTH +: ACC_WIDTH];
        assign w_i[g] = i_cap_i[g*ACC_WIDTH +: ACC_WIDTH];
    end

    always_comb begin
        w_k  = '0;
        o_re = '0;
        o_im = '0;
        if (i_row == i_col) begin
            o_re = w_diag[i_row];
        end else if (i_row < i_col) begin
            w_k  = KW'(upper_idx(N, int'(i_row), int'(i_col)));
            o_re = w_q[w_k];
            o_im = w_i[w_k];
        end else begin
            w_k  = KW'(upper_idx(N, int'(i_col), int'(i_row)));
            o_re = w_q[w_k];
            o_im = ACC_WIDTH'(sat_neg(longint'(w_i[w_k]), ACC_WIDTH));
        end
    end

endmodule

// File: rtl/cov_matrix_reader.sv
// Requests one covariance matrix, captures the packed result on the done edge and streams it.
// IDLE: wait for ireq | START: ostart pulse | WAIT_DONE: await done edge or timeout | STREAM: emit N*N
module cov_matrix_reader
    import cov_pkg::*;
#(
    parameter int  N              = 4,
    parameter int  ACC_WIDTH      = 20,
    parameter int  TIMEOUT_CYCLES = 65535,
    localparam int NU             = num_upper(N),
    localparam int RW             = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic                    ireq,
    output logic                    ostart,
    input  logic                    icalu_done,
    input  logic                    iresult_valid,
    input  logic [N*ACC_WIDTH-1:0]  iresult_diag,
    input  logic [NU*ACC_WIDTH-1:0] iresult_upper_q,
    input  logic [NU*ACC_WIDTH-1:0] iresult_upper_i,
    cov_matrix_reader_if.master     m_if,
    output logic                    obusy,
    output logic                    otimeout
);

    localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

    state_t                      r_state, w_next_state;
    logic                        r_done_prev;
    logic [31:0]                 r_tmo_cnt, w_tmo_ord;
    logic [N*ACC_WIDTH-1:0]      r_cap_diag;
    logic [NU*ACC_WIDTH-1:0]     r_cap_q, r_cap_i;
    logic                        r_ostart, r_obusy, r_otimeout, r_om_valid, r_om_last;
    logic signed [ACC_WIDTH-1:0] r_om_re, r_om_im, w_sel_re, w_sel_im;
    logic [RW-1:0]               r_om_row, r_om_col, w_nrow, w_ncol;
    logic                        w_done, w_done_rise, w_xfer;
    logic                        w_capture, w_advance, w_finish, w_nlast;
    logic                        w_ostart_nxt, w_obusy_nxt, w_tmo_nxt;

    assign w_done      = icalu_done & iresult_valid;
    assign w_done_rise = w_done & ~r_done_prev;
    assign w_xfer      = r_om_valid & m_if.im_ready;

    always_ff @(posedge iclk) begin
        if (irst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (ireq) w_next_state = ST_START;
            ST_START:     w_next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (r_otimeout)       w_next_state = ST_IDLE;
                else if (w_done_rise) w_next_state = ST_STREAM;
            end
            ST_STREAM:    if (w_xfer && r_om_last) w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // w_tmo_ord is the 1-based count of WAIT_DONE cycles the next cycle would be
    always_comb begin
        w_tmo_ord    = (r_state == ST_START) ? 32'd1 : r_tmo_cnt + 32'd1;
        w_ostart_nxt = (r_state == ST_IDLE) && (w_next_state == ST_START);
        w_obusy_nxt  = (w_next_state != ST_IDLE);
        w_tmo_nxt    = (TIMEOUT_CYCLES != 0) && (w_next_state == ST_WAIT_DONE)
                       && (w_tmo_ord == 32'(TIMEOUT_CYCLES));
        w_capture    = (r_state == ST_WAIT_DONE) && (w_next_state == ST_STREAM);
        w_advance    = (r_state == ST_STREAM) && w_xfer && !r_om_last;
        w_finish     = (r_state == ST_STREAM) && w_xfer && r_om_last;
        w_nrow       = r_om_row;
        w_ncol       = r_om_col + RW'(1);
        if (r_om_col == LAST_IDX) begin
            w_ncol = '0;
            w_nrow = r_om_row + RW'(1);
        end
        w_nlast      = (w_nrow == LAST_IDX) && (w_ncol == LAST_IDX);
    end

    cov_elem_sel #(
        .N         (N),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sel (
        .i_cap_diag (r_cap_diag),
        .i_cap_q    (r_cap_q),
        .i_cap_i    (r_cap_i),
        .i_row      (w_nrow),
        .i_col      (w_ncol),
        .o_re       (w_sel_re),
        .o_im       (w_sel_im)
    );

    // done_prev follows the level every cycle, so a level already high in START is no edge
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_ostart    <= 1'b0;
            r_obusy     <= 1'b0;
            r_otimeout  <= 1'b0;
            r_done_prev <= 1'b0;
            r_tmo_cnt   <= '0;
            r_cap_diag  <= '0;
            r_cap_q     <= '0;
            r_cap_i     <= '0;
            r_om_valid  <= 1'b0;
            r_om_last   <= 1'b0;
            r_om_re     <= '0;
            r_om_im     <= '0;
            r_om_row    <= '0;
            r_om_col    <= '0;
        end else begin
            r_ostart    <= w_ostart_nxt;
            r_obusy     <= w_obusy_nxt;
            r_otimeout  <= w_tmo_nxt;
            r_done_prev <= w_done;
            if (r_state == ST_START || r_state == ST_WAIT_DONE) r_tmo_cnt <= w_tmo_ord;
            if (w_capture) begin
                r_cap_diag <= iresult_diag;
                r_cap_q    <= iresult_upper_q;
                r_cap_i    <= iresult_upper_i;
                r_om_valid <= 1'b1;
                r_om_row   <= '0;
                r_om_col   <= '0;
                r_om_re    <= iresult_diag[ACC_WIDTH-1:0];
                r_om_im    <= '0;
                r_om_last  <= (N == 1);
            end else if (w_advance) begin
                r_om_row   <= w_nrow;
                r_om_col   <= w_ncol;
                r_om_re    <= w_sel_re;
                r_om_im    <= w_sel_im;
                r_om_last  <= w_nlast;
            end else if (w_finish) begin
                r_om_valid <= 1'b0;
                r_om_last  <= 1'b0;
            end
        end
    end

    assign ostart       = r_ostart;
    assign obusy        = r_obusy;
    assign otimeout     = r_otimeout;
    assign m_if.om_valid = r_om_valid;
    assign m_if.om_re    = r_om_re;
    assign m_if.om_im    = r_om_im;
    assign m_if.om_row   = r_om_row;
    assign m_if.om_col   = r_om_col;
    assign m_if.om_last  = r_om_last;

endmodule

// File: tb/tb_cov_matrix_reader.sv
// Scoreboard bench for cov_matrix_reader: a matrix-level model fills the expected queue,
// a negedge monitor pops and compares every transferred element.
module tb_cov_matrix_reader;

    localparam int N     = 4;
    localparam int W     = 20;
    localparam int NU    = N * (N - 1) / 2;
    localparam int T_OUT = 50;
    localparam int MAXV  = 524287;
    localparam int MINV  = -524288;

    typedef struct {
        int re;
        int im;
        int row;
        int col;
        bit last;
    } elem_t;

    logic          iclk = 1'b0;
    logic          irst, ireq, ostart, icalu_done, iresult_valid, obusy, otimeout;
    logic [N*W-1:0]  iresult_diag;
    logic [NU*W-1:0] iresult_upper_q, iresult_upper_i;

    cov_matrix_reader_if #(.N(N), .ACC_WIDTH(W)) m_if ();

    cov_matrix_reader #(
        .N              (N),
        .ACC_WIDTH      (W),
        .TIMEOUT_CYCLES (T_OUT)
    ) dut (
        .iclk            (iclk),
        .irst            (irst),
        .ireq            (ireq),
        .ostart          (ostart),
        .icalu_done      (icalu_done),
        .iresult_valid   (iresult_valid),
        .iresult_diag    (iresult_diag),
        .iresult_upper_q (iresult_upper_q),
        .iresult_upper_i (iresult_upper_i),
        .m_if            (m_if),
        .obusy           (obusy),
        .otimeout        (otimeout)
    );

    always #5 iclk = ~iclk;

    elem_t sb_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    n_xfer = 0;
    bit    bp_en  = 1'b0;
    int    diag_m [N];
    int    uq_m   [NU];
    int    ui_m   [NU];

    logic [45:0] w_snap;
    logic [48:0] w_all;
    assign w_snap = {m_if.om_valid, m_if.om_last, m_if.om_re, m_if.om_im, m_if.om_row, m_if.om_col};
    assign w_all  = {ostart, obusy, otimeout, w_snap};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int rnd20();
        logic [W-1:0] t;
        t = W'($urandom);
        return int'($signed(t));
    endfunction

    function automatic int neg_sat(input int x);
        int y;
        y = -x;
        return (y > MAXV) ? MAXV : y;
    endfunction

    task automatic random_matrix(input bit force_sat);
        for (int r = 0; r < N; r++) diag_m[r] = rnd20();
        for (int k = 0; k < NU; k++) begin
            uq_m[k] = rnd20();
            ui_m[k] = ($urandom_range(0, 7) == 0) ? MINV : rnd20();
        end
        if (force_sat) ui_m[0] = MINV;
    endtask

    task automatic drive_result();
        for (int r = 0; r < N; r++) iresult_diag[r*W +: W] = W'(diag_m[r]);
        for (int k = 0; k < NU; k++) begin
            iresult_upper_q[k*W +: W] = W'(uq_m[k]);
            iresult_upper_i[k*W +: W] = W'(ui_m[k]);
        end
    endtask

    task automatic scramble_inputs();
        for (int r = 0; r < N; r++) iresult_diag[r*W +: W] = W'($urandom);
        for (int k = 0; k < NU; k++) begin
            iresult_upper_q[k*W +: W] = W'($urandom);
            iresult_upper_i[k*W +: W] = W'($urandom);
        end
    endtask

    // Full Hermitian matrix: walk the upper triangle in packing order, mirror with conjugate
    task automatic push_expected();
        int    mre [N][N];
        int    mim [N][N];
        int    k;
        elem_t e;
        k = 0;
        for (int r = 0; r < N; r++) begin
            mre[r][r] = diag_m[r];
            mim[r][r] = 0;
            for (int c = r + 1; c < N; c++) begin
                mre[r][c] = uq_m[k];
                mim[r][c] = ui_m[k];
                mre[c][r] = uq_m[k];
                mim[c][r] = neg_sat(ui_m[k]);
                k++;
            end
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                e.re   = mre[r][c];
                e.im   = mim[r][c];
                e.row  = r;
                e.col  = c;
                e.last = (r == N - 1) && (c == N - 1);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic raise_done();
        drive_result();
        push_expected();
        icalu_done    = 1'b1;
        iresult_valid = 1'b1;
    endtask

    task automatic do_request();
        ireq = 1'b1;
        @(posedge iclk); #1;
        ireq = 1'b0;
        check("ostart_pulse", int'(ostart), 1);
        check("busy_after_req", int'(obusy), 1);
        @(posedge iclk); #1;
        check("ostart_one_cycle", int'(ostart), 0);
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((sb_q.size() != 0 || obusy) && cyc < 500) begin
            @(posedge iclk); #1;
            cyc++;
        end
        check({name, "_drained"}, sb_q.size(), 0);
        check({name, "_idle"}, int'(obusy), 0);
    endtask

    initial begin : ready_driver
        m_if.im_ready = 1'b1;
        forever begin
            @(posedge iclk); #1;
            m_if.im_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        elem_t       e;
        bit          stalled;
        logic [45:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge iclk);
            if (irst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("hold_stable", int'(w_snap != held), 0);
                if (m_if.om_valid && m_if.im_ready) begin
                    n_xfer++;
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_elem: got row=%0d col=%0d, required no element",
                                 m_if.om_row, m_if.om_col);
                    end else begin
                        e = sb_q.pop_front();
                        if (int'(m_if.om_re) != e.re || int'(m_if.om_im) != e.im ||
                            int'(m_if.om_row) != e.row || int'(m_if.om_col) != e.col ||
                            m_if.om_last != e.last) begin
                            n_fail++;
                            $display("FAIL elem: got re=%0d im=%0d row=%0d col=%0d last=%0d, required re=%0d im=%0d row=%0d col=%0d last=%0d",
                                     m_if.om_re, m_if.om_im, m_if.om_row, m_if.om_col, m_if.om_last,
                                     e.re, e.im, e.row, e.col, e.last);
                        end
                    end
                end
                stalled = m_if.om_valid && !m_if.im_ready;
                held    = w_snap;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  base, k, cyc;
        bit  saw_valid;

        irst = 1'b1; ireq = 1'b0; icalu_done = 1'b0; iresult_valid = 1'b0;
        iresult_diag = '0; iresult_upper_q = '0; iresult_upper_i = '0;
        repeat (3) @(posedge iclk);
        #1;
        check("reset_outputs", int'(|w_all), 0);
        irst = 1'b0;

        // Directed matrix with exact timing
        diag_m = '{10, 20, 30, 40};
        uq_m   = '{1, 2, 3, 4, 5, 6};
        ui_m   = '{-1, -2, -3, -4, -5, -6};
        base = n_xfer;
        do_request();
        repeat (18) @(posedge iclk);
        #1;
        check("no_valid_before_done", int'(m_if.om_valid), 0);
        raise_done();
        @(posedge iclk); #1;
        check("first_valid", int'(m_if.om_valid), 1);
        check("first_index", int'(m_if.om_row) * N + int'(m_if.om_col), 0);
        check("first_not_last", int'(m_if.om_last), 0);
        repeat (N * N - 1) @(posedge iclk);
        #1;
        check("last_flag", int'(m_if.om_last), 1);
        check("last_index", int'(m_if.om_row) * N + int'(m_if.om_col), N * N - 1);
        ireq = 1'b1;
        @(posedge iclk); #1;
        ireq = 1'b0;
        check("valid_drop", int'(m_if.om_valid), 0);
        check("busy_drop", int'(obusy), 0);
        @(posedge iclk); #1;
        check("req_at_last_ignored", int'(ostart | obusy), 0);
        icalu_done = 1'b0; iresult_valid = 1'b0;
        check("directed_count", n_xfer - base, N * N);
        check("directed_queue", sb_q.size(), 0);

        // Random data under random backpressure; first round forces saturation
        bp_en = 1'b1;
        for (int round = 0; round < 4; round++) begin
            random_matrix(round == 0);
            base = n_xfer;
            do_request();
            repeat ($urandom_range(1, 10)) @(posedge iclk);
            #1;
            raise_done();
            @(posedge iclk); #1;
            scramble_inputs();
            repeat (3) @(posedge iclk);
            #1;
            icalu_done = 1'b0; iresult_valid = 1'b0;
            wait_drain("bp_round");
            check("bp_count", n_xfer - base, N * N);
        end
        bp_en = 1'b0;
        @(posedge iclk); #1;

        // Timeout with done never asserted
        base = n_xfer;
        do_request();
        k = 1;
        saw_valid = 1'b0;
        while (!otimeout && k < 200) begin
            @(posedge iclk); #1;
            k++;
            if (m_if.om_valid) saw_valid = 1'b1;
        end
        check("timeout_cycle", k, T_OUT);
        check("timeout_no_valid", int'(saw_valid), 0);
        @(posedge iclk); #1;
        check("timeout_idle", int'(obusy), 0);
        check("timeout_single_pulse", int'(otimeout), 0);
        check("timeout_no_elems", n_xfer - base, 0);

        // Done already high on entry: only the later rising edge captures
        random_matrix(1'b0);
        drive_result();
        icalu_done = 1'b1; iresult_valid = 1'b1;
        base = n_xfer;
        do_request();
        saw_valid = 1'b0;
        repeat (10) begin
            @(posedge iclk); #1;
            if (m_if.om_valid) saw_valid = 1'b1;
        end
        check("edge_no_early_capture", int'(saw_valid), 0);
        icalu_done = 1'b0;
        repeat (2) @(posedge iclk);
        #1;
        random_matrix(1'b0);
        raise_done();
        wait_drain("edge_rule");
        check("edge_count", n_xfer - base, N * N);
        icalu_done = 1'b0; iresult_valid = 1'b0;

        // Reset in the middle of a stream, then a clean full matrix
        random_matrix(1'b1);
        do_request();
        repeat (3) @(posedge iclk);
        #1;
        raise_done();
        base = n_xfer;
        cyc = 0;
        while (n_xfer - base < 5 && cyc < 100) begin
            @(posedge iclk); #1;
            cyc++;
        end
        irst = 1'b1;
        @(posedge iclk); #1;
        check("mid_reset_zero", int'(|w_all), 0);
        check("xfers_before_reset", n_xfer - base, 5);
        sb_q.delete();
        @(posedge iclk); #1;
        irst = 1'b0;
        icalu_done = 1'b0; iresult_valid = 1'b0;
        @(posedge iclk); #1;
        random_matrix(1'b0);
        base = n_xfer;
        do_request();
        repeat (5) @(posedge iclk);
        #1;
        raise_done();
        wait_drain("after_reset");
        check("after_reset_count", n_xfer - base, N * N);
        icalu_done = 1'b0; iresult_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
